// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK transmit chain: FSM encoding and the
// carrier defaults that the modulator and sine_generator must agree on.
package bpsk_pkg;

  localparam int SAMPLE_NUMBER_DEF = 256;
  localparam int SAMPLE_WIDTH_DEF  = 12;
  localparam int CNT_WIDTH_DEF     = 8;
  localparam int DATA_WIDTH_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    SEND  = 2'd2
  } state_t;

endpackage

// File: rtl/bpsk_modulator_if.sv
// Valid/ready word stream feeding the BPSK modulator.
interface bpsk_modulator_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/bpsk_bit_serializer.sv
// MSB-first word serialiser: holds each bit for CYCLES_PER_BIT carrier periods
// and flags the boundary that ends the final period of the final bit.
module bpsk_bit_serializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int CYCLES_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  advance,
  output logic                  cur_bit,
  output logic                  last_bit_end
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PER_W = 4;  // covers period counts 0..15

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [IDX_W-1:0]      bit_idx_reg;
  logic [PER_W-1:0]      period_reg;
  logic                  period_last;

  assign period_last = (period_reg == PER_W'(CYCLES_PER_BIT - 1));

  // A load takes priority so a gapless follow-on word overrides the final advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      period_reg  <= '0;
    end else if (load) begin
      shift_reg   <= load_data;
      bit_idx_reg <= IDX_W'(DATA_WIDTH - 1);
      period_reg  <= '0;
    end else if (advance) begin
      if (period_last) begin
        period_reg  <= '0;
        shift_reg   <= shift_reg << 1;
        bit_idx_reg <= bit_idx_reg - IDX_W'(1);
      end else begin
        period_reg <= period_reg + PER_W'(1);
      end
    end
  end

  assign cur_bit      = shift_reg[DATA_WIDTH-1];
  assign last_bit_end = (bit_idx_reg == '0) && period_last;

endmodule

// File: rtl/bpsk_modulator.sv
// BPSK modulator: takes words over valid/ready and emits registered sine or
// negated-sine samples per bit, switching only on carrier-period boundaries.
module bpsk_modulator
  import bpsk_pkg::*;
#(
  parameter int SAMPLE_NUMBER  = SAMPLE_NUMBER_DEF,
  parameter int SAMPLE_WIDTH   = SAMPLE_WIDTH_DEF,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int CYCLES_PER_BIT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  bpsk_modulator_if.slave         s_if,
  input  logic [SAMPLE_WIDTH-1:0] sine_in,
  input  logic [SAMPLE_WIDTH-1:0] neg_sine_in,
  input  logic [CNT_WIDTH-1:0]    signal_cnt_in,
  output logic [SAMPLE_WIDTH-1:0] mod_out,
  output logic                    mod_valid,
  output logic                    bit_out,
  output logic                    busy
);

  state_t state_reg, state_next;
  logic   boundary;
  logic   frame_end;
  logic   transfer;
  logic   cur_bit;
  logic   last_bit_end;

  assign boundary  = en && (signal_cnt_in == CNT_WIDTH'(SAMPLE_NUMBER - 1));
  assign frame_end = (state_reg == SEND) && boundary && last_bit_end;

  // Ready opens only in IDLE or on the single cycle that ends the frame.
  assign s_if.s_ready = rst && ((state_reg == IDLE) || frame_end);
  assign transfer     = s_if.s_valid && s_if.s_ready && en && rst;
  assign busy         = (state_reg != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (transfer) state_next = ALIGN;
      ALIGN:   if (boundary) state_next = SEND;
      SEND:    if (frame_end && !transfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  bpsk_bit_serializer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_serializer (
    .clk         (clk),
    .rst         (rst),
    .load        (transfer),
    .load_data   (s_if.s_data),
    .advance     ((state_reg == SEND) && boundary),
    .cur_bit     (cur_bit),
    .last_bit_end(last_bit_end)
  );

  // One-cycle registered selection; everything holds while en is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mod_out   <= '0;
      mod_valid <= 1'b0;
      bit_out   <= 1'b0;
    end else if (en) begin
      if (state_reg == SEND) begin
        mod_out   <= cur_bit ? neg_sine_in : sine_in;
        mod_valid <= 1'b1;
        bit_out   <= cur_bit;
      end else begin
        mod_out   <= '0;
        mod_valid <= 1'b0;
        bit_out   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bpsk_modulator.sv
// Self-checking bench for bpsk_modulator: sine generator model, per-sample
// scoreboard, table of single words and hand-written multi-cycle sequences.
module tb_bpsk_modulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  cnt = 8'd0;
  logic [11:0] sine, neg_sine;
  logic [11:0] mod_out, mod_out2;
  logic        mod_valid, mod_valid2, bit_out, bit_out2, busy, busy2;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int idx2     = 0;

  bit          sb_q[$];
  logic        prev_en = 1'b0;
  logic [7:0]  prev_cnt = 8'd0;
  logic [11:0] prev_sine = '0, prev_neg = '0;

  always #5 clk = ~clk;

  function automatic logic [11:0] sine_f(input logic [7:0] c);
    return 12'(c * 13 + 100);
  endfunction

  always @(posedge clk) if (en) cnt <= cnt + 8'd1;
  always_comb begin
    sine     = sine_f(cnt);
    neg_sine = 12'(-sine_f(cnt));
  end

  bpsk_modulator_if #(.DATA_WIDTH(8)) s_if ();
  bpsk_modulator_if #(.DATA_WIDTH(8)) s_if2 ();

  bpsk_modulator #(.CYCLES_PER_BIT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .s_if(s_if),
    .sine_in(sine), .neg_sine_in(neg_sine), .signal_cnt_in(cnt),
    .mod_out(mod_out), .mod_valid(mod_valid), .bit_out(bit_out), .busy(busy)
  );

  bpsk_modulator #(.CYCLES_PER_BIT(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .s_if(s_if2),
    .sine_in(sine), .neg_sine_in(neg_sine), .signal_cnt_in(cnt),
    .mod_out(mod_out2), .mod_valid(mod_valid2), .bit_out(bit_out2), .busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Capture the inputs each edge sees; push expected bits on every accepted word.
  always @(posedge clk) begin
    prev_en   <= en;
    prev_cnt  <= cnt;
    prev_sine <= sine;
    prev_neg  <= neg_sine;
    if (!rst) sb_q.delete();
    if (s_if.s_valid && s_if.s_ready && en && rst) begin
      n_xfer++;
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 256; j++) sb_q.push_back(s_if.s_data[7-i]);
    end
  end

  always @(negedge clk) begin
    bit b;
    if (prev_en && mod_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: unexpected valid sample 0x%0h, expected none", mod_out);
      end else begin
        b = sb_q.pop_front();
        chk("sb_bit", 32'(bit_out), 32'(b));
        chk("sb_sample", 32'(mod_out), 32'(b ? prev_neg : prev_sine));
      end
    end
    if (prev_en && mod_valid2) begin
      chk("cpb2_bit", 32'(bit_out2), 32'(idx2 < 512));
      chk("cpb2_sample", 32'(mod_out2), 32'((idx2 < 512) ? prev_neg : prev_sine));
      idx2++;
    end
  end

  task automatic wait_cnt(input int c);
    int guard = 0;
    while (cnt != 8'(c) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_cnt_bound", 32'(cnt), 32'(c));
  endtask

  task automatic run_word(input logic [7:0] data, input int start, input int exp_ones);
    int guard, valid_n, ones_n;
    wait_cnt(start);
    s_if.s_data  = data;
    s_if.s_valid = 1'b1;
    @(negedge clk);
    s_if.s_valid = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("align_ready", 32'(s_ready_now()), 32'd0);
    guard = 0;
    while (!mod_valid && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    chk("first_valid_latency", 32'(guard), 32'((start == 255) ? 257 : 256 - start));
    chk("first_sample_cnt", 32'(prev_cnt), 32'd0);
    valid_n = 0;
    ones_n  = 0;
    guard   = 0;
    while ((busy || mod_valid) && guard < 5000) begin
      if (prev_en && mod_valid) begin
        valid_n++;
        ones_n += int'(bit_out);
      end
      @(negedge clk);
      guard++;
    end
    chk("word_valid_samples", 32'(valid_n), 32'd2048);
    chk("word_one_samples", 32'(ones_n), 32'(exp_ones * 256));
    chk("idle_ready", 32'(s_ready_now()), 32'd1);
    chk("idle_mod_out", 32'(mod_out), 32'd0);
  endtask

  function automatic logic s_ready_now();
    return s_if.s_ready;
  endfunction

  typedef struct {
    logic [7:0] data;
    int         start;
    int         ones;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   guard, valid_n, ones_n, gaps, flip_idx, n0;
    logic [7:0] c_frz;
    bit   started, flip_seen, froze;

    vecs[0] = '{8'hA5, 10, 4};
    vecs[1] = '{8'h3C, 255, 4};
    vecs[2] = '{8'h01, 0, 1};
    vecs[3] = '{8'hFF, 128, 8};
    vecs[4] = '{8'h00, 254, 0};
    vecs[5] = '{8'h80, 37, 1};

    rst = 1'b0;
    en  = 1'b1;
    s_if.s_data   = 8'h5A;
    s_if.s_valid  = 1'b1;
    s_if2.s_data  = 8'h00;
    s_if2.s_valid = 1'b0;

    // Reset hold with a word offered
    repeat (4) begin
      @(negedge clk);
      chk("rst_ready", 32'(s_if.s_ready), 32'd0);
      chk("rst_mod_valid", 32'(mod_valid), 32'd0);
      chk("rst_mod_out", 32'(mod_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    s_if.s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(s_if.s_ready), 32'd1);
    chk("rst_no_accept", 32'(n_xfer), 32'd0);

    foreach (vecs[k]) run_word(vecs[k].data, vecs[k].start, vecs[k].ones);

    // Back-to-back FF then 00, s_valid held across the frame boundary
    wait_cnt(100);
    n0 = n_xfer;
    s_if.s_data  = 8'hFF;
    s_if.s_valid = 1'b1;
    @(negedge clk);
    chk("b2b_first_accept", 32'(n_xfer), 32'(n0 + 1));
    s_if.s_data = 8'h00;
    valid_n = 0; ones_n = 0; gaps = 0; flip_idx = -1;
    started = 1'b0; flip_seen = 1'b0; guard = 0;
    while ((busy || mod_valid) && guard < 6000) begin
      if (n_xfer == n0 + 2) s_if.s_valid = 1'b0;
      if (mod_valid) started = 1'b1;
      if (started && !mod_valid && busy) gaps++;
      if (prev_en && mod_valid) begin
        if (!bit_out && !flip_seen) begin
          flip_seen = 1'b1;
          flip_idx  = valid_n;
          chk("b2b_flip_cnt", 32'(prev_cnt), 32'd0);
        end
        valid_n++;
        ones_n += int'(bit_out);
      end
      @(negedge clk);
      guard++;
    end
    s_if.s_valid = 1'b0;
    chk("b2b_second_accept", 32'(n_xfer), 32'(n0 + 2));
    chk("b2b_valid_samples", 32'(valid_n), 32'd4096);
    chk("b2b_one_samples", 32'(ones_n), 32'd2048);
    chk("b2b_gaps", 32'(gaps), 32'd0);
    chk("b2b_flip_index", 32'(flip_idx), 32'd2048);

    // en freeze for 50 cycles in the middle of bit 3 of A5
    wait_cnt(40);
    s_if.s_data  = 8'hA5;
    s_if.s_valid = 1'b1;
    @(negedge clk);
    s_if.s_valid = 1'b0;
    valid_n = 0; guard = 0; froze = 1'b0;
    while ((busy || mod_valid) && guard < 6000) begin
      if (prev_en && mod_valid) valid_n++;
      if (valid_n == 3 * 256 + 100 && !froze) begin
        froze = 1'b1;
        en    = 1'b0;
        c_frz = cnt;
        repeat (50) begin
          @(negedge clk);
          chk("frz_bit_out", 32'(bit_out), 32'd0);
          chk("frz_mod_out", 32'(mod_out), 32'(sine_f(c_frz - 8'd1)));
          chk("frz_busy", 32'(busy), 32'd1);
        end
        en = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    chk("frz_happened", 32'(froze), 32'd1);
    chk("frz_valid_samples", 32'(valid_n), 32'd2048);

    // Reset pulse during bit 5 aborts the frame
    wait_cnt(3);
    s_if.s_data  = 8'hA5;
    s_if.s_valid = 1'b1;
    @(negedge clk);
    s_if.s_valid = 1'b0;
    valid_n = 0; guard = 0;
    while (guard < 3000) begin
      if (prev_en && mod_valid) valid_n++;
      if (valid_n == 5 * 256 + 30) begin
        rst = 1'b0;
        @(negedge clk);
        chk("abort_mod_valid", 32'(mod_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready_in_rst", 32'(s_if.s_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", 32'(s_if.s_ready), 32'd1);
        chk("abort_mod_out", 32'(mod_out), 32'd0);
        break;
      end
      @(negedge clk);
      guard++;
    end
    chk("abort_reached", 32'(valid_n), 32'(5 * 256 + 30));
    run_word(8'h01, 77, 1);

    // CYCLES_PER_BIT=2 instance, word 80
    wait_cnt(200);
    s_if2.s_data  = 8'h80;
    s_if2.s_valid = 1'b1;
    @(negedge clk);
    s_if2.s_valid = 1'b0;
    chk("cpb2_busy", 32'(busy2), 32'd1);
    guard = 0;
    while ((busy2 || mod_valid2) && guard < 9000) begin
      @(negedge clk);
      guard++;
    end
    chk("cpb2_total_samples", 32'(idx2), 32'd4096);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bpsk_modulator.md
Name: bpsk_modulator

Overview:
- Downstream consumer of sine_generator in the BPSK transmit chain.
- Accepts parallel data words over a valid/ready handshake and serialises them MSB first.
- For each bit it selects the generator's sine (bit 0) or negated sine (bit 1), aligned to carrier-period boundaries, and emits registered modulated samples toward the DAC/channel stage.
- Shares the generator's en, so both blocks pause together.

Parameters:
- SAMPLE_NUMBER, 256: samples per carrier period. Must match sine_generator.
- SAMPLE_WIDTH, 12: sample width in bits.
- CNT_WIDTH, 8: width of signal_cnt, equal to clog2(SAMPLE_NUMBER).
- DATA_WIDTH, 8: bits per input word.
- CYCLES_PER_BIT, 1: carrier periods per transmitted bit, legal range 1..16.

Ports:
- clk, input, 1: system clock. Single clock domain.
- rst, input, 1: synchronous active-low reset.
- en, input, 1: global enable, shared with sine_generator.
- s_data, input, DATA_WIDTH: word to transmit.
- s_valid, input, 1: s_data valid.
- s_ready, output, 1: block can accept a word.
- sine_in, input, SAMPLE_WIDTH: from generator sine_out.
- neg_sine_in, input, SAMPLE_WIDTH: from generator neg_sine_out.
- signal_cnt_in, input, CNT_WIDTH: from generator signal_cnt.
- mod_out, output, SAMPLE_WIDTH: modulated sample, registered.
- mod_valid, output, 1: mod_out carries a data-bearing sample.
- bit_out, output, 1: bit currently being modulated, registered and aligned with mod_out.
- busy, output, 1: state is not IDLE.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State returns to IDLE; shift register, bit counter and period counter clear to 0.
  - mod_out=0, mod_valid=0, bit_out=0.
  - s_ready is forced 0 while rst==0.
  - Reset mid-frame aborts the frame; remaining bits are discarded with no partial completion.
- Handshake:
  - A transfer occurs on a clk edge where s_valid && s_ready && en && rst.
  - s_data is captured into the shift register on that edge.
  - s_valid must hold until accepted; the block never drops an offered word.
- Boundary definition: boundary = en && (signal_cnt_in == SAMPLE_NUMBER-1), i.e. the last sample of a carrier period.
- State IDLE:
  - s_ready=1. mod_out=0, mod_valid=0.
  - On a transfer, go to ALIGN.
- State ALIGN:
  - s_ready=0.
  - On boundary, go to SEND. Bit index = DATA_WIDTH-1, period counter = 0.
  - An accept coinciding with a boundary still passes through ALIGN, so the first bit always starts at signal_cnt_in==0 of the next period.
- State SEND, each en cycle:
  - mod_out <= cur_bit ? neg_sine_in : sine_in.
  - mod_valid <= 1, bit_out <= cur_bit.
  - Latency is exactly 1 clk from sine_in/signal_cnt_in to mod_out.
- SEND, bit advance on boundary:
  - If period counter < CYCLES_PER_BIT-1: increment period counter.
  - Else: reset period counter to 0 and move to the next bit (shift left).
- SEND, end of last bit (final bit, final period, boundary):
  - s_ready=1 combinationally in this cycle only.
  - If a transfer occurs: load the new word and stay in SEND at bit DATA_WIDTH-1. The stream is gapless and phase continues.
  - If no transfer: go to IDLE. mod_valid becomes 0 and mod_out becomes 0 on the following edge.
- en==0:
  - All state, counters and outputs hold.
  - No transfer (s_ready may be 1, but a transfer requires en).
- Arithmetic: pure selection, no sign manipulation. Widths of sine_in and neg_sine_in pass through unchanged.
- Simultaneous reset and transfer: reset wins and the word is not accepted.

Decomposition:
- Shared package/header bpsk_pkg holds:
  - State encoding: IDLE=2'd0, ALIGN=2'd1, SEND=2'd2.
  - Defaults for SAMPLE_NUMBER, SAMPLE_WIDTH, CNT_WIDTH, reused by sine_generator.
- One sub-module, bpsk_bit_serializer. It contains the shift register, bit index counter and period counter. It exposes cur_bit and last_bit_end, and takes load/advance strobes.
- Top level keeps the FSM, handshake logic and output mux/registers.

Test Plan:
- Reset hold: rst=0 for 4 cycles with s_valid=1 -> s_ready=0, mod_out=0, mod_valid=0, busy=0; no word accepted.
- Single word 8'hA5, en=1, accepted at signal_cnt=10 -> ALIGN until cnt=255; mod_valid rises one clk after cnt=0.
  - Bit sequence 1,0,1,0,0,1,0,1, each lasting 256 samples.
  - mod_out equals neg_sine_in for 1-bits and sine_in for 0-bits, delayed one cycle.
  - Returns to IDLE after 2048 samples.
- Back-to-back 8'hFF then 8'h00 with s_valid held -> second word accepted on the final boundary of the first.
  - mod_valid stays 1 continuously for 4096 samples; phase flips exactly at the word boundary.
- en deasserted for 50 cycles mid-bit 3 -> mod_out, bit_out and counters frozen. Resumes with the same bit, so total bit length is still 256 en-cycles.
- rst pulse mid-frame at bit 5 -> next cycle mod_valid=0, state IDLE, s_ready=1 after release; new word 8'h01 is transmitted from its MSB.
- CYCLES_PER_BIT=2, word 8'h80 -> first bit lasts 512 samples of neg_sine_in, then 7×512 samples of sine_in.
